// File: rtl/pool_channel_scheduler.sv
// pool_channel_scheduler: queues multi-channel pooling job descriptors and runs each job as a
// series of single-channel core runs, stepping feature/result bases by per-job strides.
module pool_channel_scheduler #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned CH_WIDTH    = 16,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [ADDR_WIDTH-1:0]          cmd_feature_addr,
   input  logic [ADDR_WIDTH-1:0]          cmd_result_addr,
   input  logic [ADDR_WIDTH-1:0]          cmd_feature_stride,
   input  logic [ADDR_WIDTH-1:0]          cmd_result_stride,
   input  logic [CH_WIDTH-1:0]            cmd_channels,
   input  logic                           core_ready,
   output logic                           core_go,
   input  logic                           core_done,
   output logic [ADDR_WIDTH-1:0]          core_feature_addr,
   output logic [ADDR_WIDTH-1:0]          core_result_addr,
   input  logic                           irq_en,
   input  logic                           irq_clr,
   output logic                           interrupt,
   output logic                           busy,
   output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
   output logic [CNT_WIDTH-1:0]           done_count
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StIssue,
      StWait,
      StNext,
      StDone
   } state_e;

   state_e state;

   // Descriptor queue storage, one array per field
   logic [ADDR_WIDTH-1:0] q_feat    [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] q_res     [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] q_fstride [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] q_rstride [QUEUE_DEPTH];
   logic [CH_WIDTH-1:0]   q_ch      [QUEUE_DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   // Active job descriptor
   logic [ADDR_WIDTH-1:0] job_feat;
   logic [ADDR_WIDTH-1:0] job_res;
   logic [ADDR_WIDTH-1:0] job_fstride;
   logic [ADDR_WIDTH-1:0] job_rstride;
   logic [CH_WIDTH-1:0]   job_ch;
   logic [CH_WIDTH-1:0]   ch_idx;

   assign cmd_ready = (queue_level != LVL_W'(QUEUE_DEPTH));
   assign push      = cmd_valid & cmd_ready;
   // The head is only consumed while the FSM sits in IDLE
   assign pop       = (state == StIdle) && (queue_level != '0);
   assign busy      = (state != StIdle) || (queue_level != '0);

   // Queue payload write; contents need no reset since the pointers gate every read
   always_ff @(posedge ACLK) begin
      if (push) begin
         q_feat[wr_ptr]    <= cmd_feature_addr;
         q_res[wr_ptr]     <= cmd_result_addr;
         q_fstride[wr_ptr] <= cmd_feature_stride;
         q_rstride[wr_ptr] <= cmd_result_stride;
         q_ch[wr_ptr]      <= cmd_channels;
      end
   end

   // Queue pointers and occupancy; power-of-two depth lets the pointers wrap naturally
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         queue_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop) begin
            queue_level <= queue_level + LVL_W'(1);
         end else if (!push && pop) begin
            queue_level <= queue_level - LVL_W'(1);
         end
      end
   end

   // Job FSM with registered core strobe, addresses, counter and interrupt
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state             <= StIdle;
         core_go           <= 1'b0;
         core_feature_addr <= '0;
         core_result_addr  <= '0;
         ch_idx            <= '0;
         job_feat          <= '0;
         job_res           <= '0;
         job_fstride       <= '0;
         job_rstride       <= '0;
         job_ch            <= '0;
         done_count        <= '0;
         interrupt         <= 1'b0;
      end else begin
         core_go <= 1'b0;
         // A set in DONE below overrides this clear
         if (irq_clr) interrupt <= 1'b0;

         unique case (state)
            StIdle: begin
               if (pop) begin
                  job_feat    <= q_feat[rd_ptr];
                  job_res     <= q_res[rd_ptr];
                  job_fstride <= q_fstride[rd_ptr];
                  job_rstride <= q_rstride[rd_ptr];
                  job_ch      <= q_ch[rd_ptr];
                  state       <= StLoad;
               end
            end
            StLoad: begin
               ch_idx            <= '0;
               core_feature_addr <= job_feat;
               core_result_addr  <= job_res;
               state             <= (job_ch == '0) ? StDone : StIssue;
            end
            StIssue: begin
               if (core_ready) begin
                  core_go <= 1'b1;
                  state   <= StWait;
               end
            end
            StWait: begin
               // A done coincident with our own go belongs to no run of ours
               if (core_done && !core_go) begin
                  state <= (ch_idx == job_ch - CH_WIDTH'(1)) ? StDone : StNext;
               end
            end
            StNext: begin
               ch_idx            <= ch_idx + CH_WIDTH'(1);
               core_feature_addr <= core_feature_addr + job_fstride;
               core_result_addr  <= core_result_addr + job_rstride;
               state             <= StIssue;
            end
            StDone: begin
               done_count <= done_count + CNT_WIDTH'(1);
               if (irq_en) interrupt <= 1'b1;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_channel_scheduler.sv
// tb_pool_channel_scheduler: directed stimulus, a job-level reference model checked every
// cycle, and literal expectations for the documented scenarios.
module tb_pool_channel_scheduler;

   localparam int AW = 32;
   localparam int CW = 16;
   localparam int QD = 4;
   localparam int NW = 16;

   logic            ACLK = 1'b0;
   logic            ARESET;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [AW-1:0]   cmd_feature_addr;
   logic [AW-1:0]   cmd_result_addr;
   logic [AW-1:0]   cmd_feature_stride;
   logic [AW-1:0]   cmd_result_stride;
   logic [CW-1:0]   cmd_channels;
   logic            core_ready;
   logic            core_go;
   logic            core_done;
   logic [AW-1:0]   core_feature_addr;
   logic [AW-1:0]   core_result_addr;
   logic            irq_en;
   logic            irq_clr;
   logic            interrupt;
   logic            busy;
   logic [2:0]      queue_level;
   logic [NW-1:0]   done_count;

   logic            resp_done;
   logic            stray_done;
   assign core_done = resp_done | stray_done;

   always #5 ACLK = ~ACLK;

   pool_channel_scheduler #(
      .ADDR_WIDTH  (AW),
      .CH_WIDTH    (CW),
      .QUEUE_DEPTH (QD),
      .CNT_WIDTH   (NW)
   ) dut (
      .ACLK               (ACLK),
      .ARESET             (ARESET),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_feature_addr   (cmd_feature_addr),
      .cmd_result_addr    (cmd_result_addr),
      .cmd_feature_stride (cmd_feature_stride),
      .cmd_result_stride  (cmd_result_stride),
      .cmd_channels       (cmd_channels),
      .core_ready         (core_ready),
      .core_go            (core_go),
      .core_done          (core_done),
      .core_feature_addr  (core_feature_addr),
      .core_result_addr   (core_result_addr),
      .irq_en             (irq_en),
      .irq_clr            (irq_clr),
      .interrupt          (interrupt),
      .busy               (busy),
      .queue_level        (queue_level),
      .done_count         (done_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Core stand-in: answers each core_go with core_done resp_delay cycles later
   int resp_delay = 10;
   bit auto_resp  = 1'b0;
   int resp_cnt   = 0;
   initial begin
      resp_done = 1'b0;
      forever begin
         @(posedge ACLK); #1;
         resp_done = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) resp_done = 1'b1;
         end
         if (core_go && auto_resp) resp_cnt = resp_delay;
      end
   end

   // Job-level model: every accepted job expands into its list of channel addresses
   logic [AW-1:0] exp_f_q[$];
   logic [AW-1:0] exp_r_q[$];
   int            end_q[$];
   int            accepted, jobs_done, gos_seen, gos_total;
   logic [NW-1:0] last_done;
   bit            exp_irq, prev_en, prev_clr;

   initial begin
      logic [63:0] fa, ra;
      int          exp_end;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            exp_f_q.delete();
            exp_r_q.delete();
            end_q.delete();
            accepted  = 0;
            jobs_done = 0;
            gos_seen  = 0;
            gos_total = 0;
            last_done = '0;
            exp_irq   = 1'b0;
            prev_en   = 1'b0;
            prev_clr  = 1'b0;
            continue;
         end
         if (core_go) begin
            if (exp_f_q.size() == 0) begin
               check("core_go with no channel pending", 64'(core_go), 64'(0));
            end else begin
               check("model core_feature_addr", 64'(core_feature_addr), 64'(exp_f_q.pop_front()));
               check("model core_result_addr", 64'(core_result_addr), 64'(exp_r_q.pop_front()));
               gos_seen++;
            end
         end
         if (done_count != last_done) begin
            check("model done_count step", 64'(done_count), 64'(NW'(last_done + 1'b1)));
            exp_end = -1;
            if (end_q.size() != 0) exp_end = end_q.pop_front();
            check("model channel runs at job end", 64'(gos_seen), 64'(exp_end));
            jobs_done++;
            last_done = done_count;
            if (prev_en) exp_irq = 1'b1;
            else if (prev_clr) exp_irq = 1'b0;
         end else if (prev_clr) begin
            exp_irq = 1'b0;
         end
         check("model busy", 64'(busy), 64'(accepted != jobs_done));
         check("model interrupt", 64'(interrupt), 64'(exp_irq));
         if (cmd_valid && cmd_ready) begin
            accepted++;
            for (int i = 0; i < int'(cmd_channels); i++) begin
               fa = 64'(cmd_feature_addr) + 64'(i) * 64'(cmd_feature_stride);
               ra = 64'(cmd_result_addr) + 64'(i) * 64'(cmd_result_stride);
               exp_f_q.push_back(AW'(fa));
               exp_r_q.push_back(AW'(ra));
            end
            gos_total += int'(cmd_channels);
            end_q.push_back(gos_total);
         end
         prev_en  = irq_en;
         prev_clr = irq_clr;
      end
   end

   task automatic tick();
      @(posedge ACLK); #1;
   endtask

   // Call just after a rising edge; returns just after the edge that accepted the job
   task automatic push_job(input logic [AW-1:0] f, input logic [AW-1:0] r,
                           input logic [AW-1:0] fs, input logic [AW-1:0] rs,
                           input logic [CW-1:0] ch);
      bit acc = 1'b0;
      int n = 0;
      cmd_feature_addr   = f;
      cmd_result_addr    = r;
      cmd_feature_stride = fs;
      cmd_result_stride  = rs;
      cmd_channels       = ch;
      cmd_valid          = 1'b1;
      while (!acc && n < 400) begin
         @(negedge ACLK);
         acc = cmd_ready;
         tick();
         n++;
      end
      cmd_valid = 1'b0;
      if (!acc) check("cmd accept timeout", 64'(acc), 64'(1));
   endtask

   task automatic wait_go(input logic [AW-1:0] ef, input logic [AW-1:0] er, output int n);
      n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (!core_go && n < 200);
      check("core_go seen", 64'(core_go), 64'(1));
      check("core_feature_addr", 64'(core_feature_addr), 64'(ef));
      check("core_result_addr", 64'(core_result_addr), 64'(er));
   endtask

   task automatic wait_done(input logic [NW-1:0] target);
      int n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (done_count != target && n < 2000);
      check("done_count", 64'(done_count), 64'(target));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int gos;
      ARESET             = 1'b1;
      cmd_valid          = 1'b0;
      cmd_feature_addr   = '0;
      cmd_result_addr    = '0;
      cmd_feature_stride = '0;
      cmd_result_stride  = '0;
      cmd_channels       = '0;
      core_ready         = 1'b1;
      irq_en             = 1'b0;
      irq_clr            = 1'b0;
      stray_done         = 1'b0;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;

      // Reset values
      @(negedge ACLK);
      check("reset cmd_ready", 64'(cmd_ready), 64'(1));
      check("reset core_go", 64'(core_go), 64'(0));
      check("reset interrupt", 64'(interrupt), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      check("reset queue_level", 64'(queue_level), 64'(0));
      check("reset done_count", 64'(done_count), 64'(0));
      check("reset core_feature_addr", 64'(core_feature_addr), 64'(0));

      // Single 3-channel job
      tick();
      irq_en     = 1'b1;
      auto_resp  = 1'b1;
      resp_delay = 10;
      push_job(32'h1000, 32'h8000, 32'h400, 32'h100, 16'd3);
      wait_go(32'h1000, 32'h8000, n);
      check("accept to core_go latency", 64'(n), 64'(4));
      wait_go(32'h1400, 32'h8100, n);
      check("channel gap", 64'(n), 64'(13));
      wait_go(32'h1800, 32'h8200, n);
      check("channel gap", 64'(n), 64'(13));
      wait_done(16'd1);
      check("job1 interrupt", 64'(interrupt), 64'(1));
      tick();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      @(negedge ACLK);
      check("interrupt after clear", 64'(interrupt), 64'(0));

      // Queue fill while the core is held off
      tick();
      core_ready = 1'b0;
      resp_delay = 5;
      for (int k = 1; k <= 5; k++) begin
         push_job(AW'(32'h100 * k), AW'(32'h2000 + 32'h10 * k), 32'h0, 32'h0, 16'd1);
      end
      @(negedge ACLK);
      check("full queue_level", 64'(queue_level), 64'(4));
      check("full cmd_ready", 64'(cmd_ready), 64'(0));
      check("full busy", 64'(busy), 64'(1));
      repeat (3) begin
         @(negedge ACLK);
         check("held cmd_ready", 64'(cmd_ready), 64'(0));
      end
      tick();
      core_ready = 1'b1;
      push_job(32'h5000, 32'h6000, 32'h40, 32'h20, 16'd2);
      wait_done(16'd7);

      // Zero-channel job completes without a core run
      tick();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      push_job(32'h9000, 32'h9100, 32'h4, 32'h4, 16'd0);
      n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (done_count == 16'd7 && n < 20);
      check("zero-channel done latency", 64'(n), 64'(4));
      check("zero-channel done_count", 64'(done_count), 64'(8));
      check("zero-channel interrupt", 64'(interrupt), 64'(1));

      // irq_clr coinciding with DONE: the set wins
      tick();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      push_job(32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
      tick();
      tick();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      @(negedge ACLK);
      check("set beats clear done_count", 64'(done_count), 64'(9));
      check("set beats clear interrupt", 64'(interrupt), 64'(1));

      // irq_en=0 masks new sets but keeps a pending interrupt
      tick();
      irq_en = 1'b0;
      push_job(32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
      wait_done(16'd10);
      check("masked keeps pending", 64'(interrupt), 64'(1));
      tick();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      push_job(32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
      wait_done(16'd11);
      check("masked no set", 64'(interrupt), 64'(0));
      irq_en = 1'b1;

      // Address wrap
      tick();
      resp_delay = 10;
      push_job(32'hFFFF_FF00, 32'h0, 32'h200, 32'h10, 16'd2);
      wait_go(32'hFFFF_FF00, 32'h0, n);
      wait_go(32'h0000_0100, 32'h10, n);
      wait_done(16'd12);

      // Stray core_done in IDLE and in the core_go cycle
      tick();
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      @(negedge ACLK);
      check("stray idle done_count", 64'(done_count), 64'(12));
      check("stray idle busy", 64'(busy), 64'(0));
      tick();
      push_job(32'h300, 32'h400, 32'h10, 32'h20, 16'd2);
      n = 0;
      while (!core_go && n < 50) begin
         tick();
         n++;
      end
      check("stray go found", 64'(core_go), 64'(1));
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      wait_go(32'h310, 32'h420, n);
      check("stray ignored gap", 64'(n), 64'(13));
      wait_done(16'd13);

      // Reset during WAIT of channel 1 of a 4-channel job
      tick();
      push_job(32'hA000, 32'hB000, 32'h100, 32'h100, 16'd4);
      wait_go(32'hA000, 32'hB000, n);
      wait_go(32'hA100, 32'hB100, n);
      tick();
      ARESET    = 1'b1;
      auto_resp = 1'b0;
      tick();
      ARESET = 1'b0;
      @(negedge ACLK);
      check("midjob reset core_go", 64'(core_go), 64'(0));
      check("midjob reset busy", 64'(busy), 64'(0));
      check("midjob reset queue_level", 64'(queue_level), 64'(0));
      check("midjob reset done_count", 64'(done_count), 64'(0));
      check("midjob reset interrupt", 64'(interrupt), 64'(0));
      check("midjob reset feature addr", 64'(core_feature_addr), 64'(0));
      check("midjob reset result addr", 64'(core_result_addr), 64'(0));
      check("midjob reset cmd_ready", 64'(cmd_ready), 64'(1));
      gos = 0;
      repeat (40) begin
         @(negedge ACLK);
         if (core_go) gos++;
      end
      check("core_go after reset", 64'(gos), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
